// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaled period counter (edge- or centre-aligned)
// with double-buffered per-channel duty values applied only at period boundaries.
module pwm_multi #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS*WIDTH-1:0] level,
  input  logic                      level_load,
  output logic                      update_pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       out
);

  localparam logic [WIDTH-1:0] MaxCnt = '1;

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [PRESCALE_W-1:0]            pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]                 count_q, count_d;
  dir_e                             dir_q, dir_d;
  logic                             mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   active_q, active_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   pending_q, pending_d;
  logic                             update_pending_d;
  logic                             period_start_d;
  logic [CHANNELS-1:0]              out_d;
  logic                             tick;
  logic                             boundary;
  logic                             transfer;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    boundary  = 1'b0;
    tick      = enable && (pre_cnt_q == prescale);

    if (!enable) begin
      pre_cnt_d = '0;
      count_d   = '0;
      dir_d     = DirUp;
      mode_d    = center_mode;
    end else if (tick) begin
      pre_cnt_d = '0;
      if (!mode_q) begin
        count_d  = count_q + 1'b1;
        dir_d    = DirUp;
        boundary = (count_q == MaxCnt);
      end else if (dir_q == DirUp) begin
        count_d = count_q + 1'b1;
        if (count_q == MaxCnt - 1'b1) begin
          dir_d = DirDown;
        end
      end else begin
        count_d = count_q - 1'b1;
        if (count_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          dir_d    = DirUp;
          boundary = 1'b1;
        end
      end
      if (boundary) begin
        mode_d = center_mode;
      end
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end

    // While idle the shadow is applied every cycle; a coincident load stays pending.
    transfer         = update_pending && (boundary || !enable);
    active_d         = transfer ? pending_q : active_q;
    pending_d        = level_load ? level : pending_q;
    update_pending_d = level_load || (update_pending && !transfer);
    period_start_d   = boundary;

    for (int i = 0; i < CHANNELS; i++) begin
      out_d[i] = enable && (count_q < active_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q      <= '0;
      count_q        <= '0;
      dir_q          <= DirUp;
      mode_q         <= 1'b0;
      active_q       <= '0;
      pending_q      <= '0;
      update_pending <= 1'b0;
      period_start   <= 1'b0;
      out            <= '0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      count_q        <= count_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      update_pending <= update_pending_d;
      period_start   <= period_start_d;
      out            <= out_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Randomised scoreboard bench for pwm_multi: a phase-based period model predicts each
// cycle's outputs; a monitor pops and compares after every clock edge.
module tb_pwm_multi;

  localparam int MAXV = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        center_mode = 1'b0;
  logic [7:0]  prescale = '0;
  logic [23:0] level = '0;
  logic        level_load = 1'b0;
  logic        update_pending;
  logic        period_start;
  logic [2:0]  out;

  pwm_multi #(.CHANNELS(3), .WIDTH(8), .PRESCALE_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .center_mode    (center_mode),
    .prescale       (prescale),
    .level          (level),
    .level_load     (level_load),
    .update_pending (update_pending),
    .period_start   (period_start),
    .out            (out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] o;
    logic       ps;
    logic       up;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  // Reference model: position within the period plus shadow/active duty sets.
  int   m_pc, m_p, m_mode;
  int   m_act[3], m_pend[3];
  bit   m_flag;
  bit   cur_en, cur_cm;

  function automatic int m_count();
    if (m_mode != 0) return (m_p <= MAXV) ? m_p : 2 * MAXV - m_p;
    return m_p;
  endfunction

  function automatic int m_period();
    return (m_mode != 0) ? 2 * MAXV : MAXV + 1;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_p = 0; m_mode = 0; m_flag = 0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_pend[i] = 0;
    end
  endtask

  // Drive one cycle of inputs and push what the DUT must show after the next edge.
  task automatic step(input bit en, input bit cm, input int ps, input bit [23:0] lv,
                      input bit ld);
    exp_t e;
    bit   bdy;
    enable = en; center_mode = cm; prescale = 8'(ps); level = lv; level_load = ld;
    for (int i = 0; i < 3; i++) e.o[i] = en && (m_count() < m_act[i]);
    bdy = 0;
    if (!en) begin
      m_pc = 0; m_p = 0; m_mode = cm;
    end else if (m_pc == ps) begin
      m_pc = 0;
      if (m_p == m_period() - 1) begin
        bdy = 1; m_p = 0; m_mode = cm;
      end else begin
        m_p++;
      end
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
    if (m_flag && (bdy || !en)) begin
      for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
      m_flag = 0;
    end
    if (ld) begin
      for (int i = 0; i < 3; i++) m_pend[i] = int'(lv[i*8 +: 8]);
      m_flag = 1;
    end
    e.ps = bdy;
    e.up = m_flag;
    q.push_back(e);
  endtask

  function automatic bit [7:0] rand_level();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic run(input int cycles, input int ps, input bit tog_en, input bit tog_cm);
    bit ld;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (tog_en && $urandom_range(0, 199) == 0) cur_en = !cur_en;
      if (tog_cm && $urandom_range(0, 299) == 0) cur_cm = !cur_cm;
      // Bias loads onto the boundary cycle to exercise the set-wins-over-clear case.
      if (cur_en && m_pc == ps && m_p == m_period() - 1) ld = ($urandom_range(0, 1) == 0);
      else ld = ($urandom_range(0, 149) == 0);
      step(cur_en, cur_cm, ps, {rand_level(), rand_level(), rand_level()}, ld);
    end
  endtask

  task automatic drain();
    int budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outs(input string name);
    n_tests++;
    if (out !== 3'b000 || update_pending !== 1'b0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: out/ps/up got %b/%b/%b, required 000/0/0", name, out, period_start,
               update_pending);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    n_cyc++;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (out !== e.o || period_start !== e.ps || update_pending !== e.up) begin
        n_fail++;
        $display("FAIL cycle%0d out/period_start/update_pending: got %b/%b/%b, required %b/%b/%b",
                 n_cyc, out, period_start, update_pending, e.o, e.ps, e.up);
      end
    end
  end

  initial begin
    model_reset();
    cur_en = 1; cur_cm = 0;
    #12;
    check_reset_outs("reset_initial");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 0, {8'd0, 8'd0, 8'd64}, 1'b1);
    run(2000, 0, 1'b0, 1'b0);
    run(4200, 3, 1'b0, 1'b0);
    run(600, 5, 1'b0, 1'b0);
    run(1500, 1, 1'b0, 1'b0);
    cur_cm = 1;
    run(3000, 0, 1'b0, 1'b1);
    run(3000, 0, 1'b1, 1'b1);
    run(2000, 2, 1'b1, 1'b1);
    cur_en = 1; cur_cm = 0;
    run(300, 0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset in the middle of a running period.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outs("reset_async");
    @(negedge clk);
    check_reset_outs("reset_held");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 0, {8'd10, 8'd200, 8'd77}, 1'b0);
    run(600, 0, 1'b0, 1'b0);
    run(800, 0, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
